// File: rtl/count_sched.sv
// Round-robin scheduler that lends one shared W-bit up-counter to NREQ requesters.
// Latency: gnt 1 cycle after req seen in IDLE, done 3+target cycles after, next gnt 5+target.
// Backpressure: req is a held level; a grant runs to done or abort, others wait (no preemption).
module count_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      result,
  output logic              busy,
  output logic              cnt_clr,
  output logic              cnt_en,
  input  logic [W-1:0]      cnt_q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [W-1:0]    r_result;
  logic [PW-1:0]   r_ptr;
  logic [W-1:0]    r_target;

  logic            w_any;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_cand;
  logic [NREQ-1:0] w_win_oh;

  // Round-robin pick: first asserted req scanning upward from the one after the last winner
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_any && req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  // One-hot form of the winner, used to load the grant register
  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  // Scheduler FSM; r_ptr doubles as the index of the requester currently being served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_ptr    <= PW'(NREQ - 1);
      r_target <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt    <= w_win_oh;
            r_target <= len[int'(w_win)*W +: W];
            r_ptr    <= w_win;
            r_state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          // Abort wins over completion: a dropped request never sees done
          if (!req[r_ptr]) begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end else if (cnt_q == r_target) begin
            r_done   <= r_gnt;
            r_result <= cnt_q;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Counter controls decode straight from state so reset silences them without a clock
  assign cnt_clr = (r_state == S_CLEAR);
  assign cnt_en  = (r_state == S_RUN) && (cnt_q != r_target);
  assign busy    = (r_state != S_IDLE);

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched with a behavioural shared counter and a queue-based scoreboard.
// Stimulus pushes expected grants/completions; a negedge monitor pops and compares.
// All waits are fixed cycle counts, so the run always reaches its summary.
module tb_count_sched;
  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req   = '0;
  logic [NREQ*W-1:0] len   = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      result;
  logic              busy;
  logic              cnt_clr;
  logic              cnt_en;
  logic [W-1:0]      cnt_q = '0;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int t0     = 0;

  typedef struct {
    logic [NREQ-1:0] gnt;
    int              cyc;
  } gexp_t;

  typedef struct {
    logic [NREQ-1:0] done;
    logic [W-1:0]    result;
    int              cyc;
  } dexp_t;

  gexp_t q_gnt[$];
  dexp_t q_done[$];
  gexp_t m_g;
  dexp_t m_d;
  logic [NREQ-1:0] prev_gnt = '0;

  count_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .len    (len),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .busy   (busy),
    .cnt_clr(cnt_clr),
    .cnt_en (cnt_en),
    .cnt_q  (cnt_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared counter: clear beats enable, otherwise hold
  always @(posedge clk) begin
    if (cnt_clr)     cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_q + 4'd1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_gnt(input logic [NREQ-1:0] g, input int c);
    gexp_t e;
    e.gnt = g;
    e.cyc = c;
    q_gnt.push_back(e);
  endtask

  task automatic push_done(input logic [NREQ-1:0] d, input logic [W-1:0] r, input int c);
    dexp_t e;
    e.done   = d;
    e.result = r;
    e.cyc    = c;
    q_done.push_back(e);
  endtask

  // Monitor: invariants every cycle, scoreboard pops on new grant and on done
  always @(negedge clk) begin
    check("gnt_onehot0_done_in_gnt",
          int'($onehot0(gnt) && $onehot0(done) && ((done & ~gnt) == '0)), 1);
    if (gnt != '0 && prev_gnt == '0) begin
      if (q_gnt.size() == 0) begin
        check("unexpected_gnt", int'(gnt), 0);
      end else begin
        m_g = q_gnt.pop_front();
        check("gnt_value", int'(gnt), int'(m_g.gnt));
        check("gnt_cycle", cyc, m_g.cyc);
      end
    end
    prev_gnt = gnt;
    if (done != '0) begin
      if (q_done.size() == 0) begin
        check("unexpected_done", int'(done), 0);
      end else begin
        m_d = q_done.pop_front();
        check("done_value", int'(done), int'(m_d.done));
        check("done_result", int'(result), int'(m_d.result));
        check("done_cycle", cyc, m_d.cyc);
      end
    end
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_clr", int'(cnt_clr), 0);
    check("rst_en", int'(cnt_en), 0);
    rst_n = 1'b1;
    tick();

    // Contention straight out of reset: order 0,1,2,3,0, period 5 cycles
    len = 16'h1111;
    req = 4'b1111;
    t0  = cyc;
    for (int k = 0; k < 5; k++) begin
      push_gnt(4'(1 << (k % 4)), t0 + 1 + 5*k);
      push_done(4'(1 << (k % 4)), 4'd1, t0 + 4 + 5*k);
    end
    for (int c = 1; c <= 25; c++) begin
      tick();
      check("cont_busy", int'(busy), int'(((c - 1) % 5) < 4));
      if (c == 24) req = '0;
    end

    // Single request, target 3
    len[7:4] = 4'd3;
    req = 4'b0010;
    t0  = cyc;
    push_gnt(4'b0010, t0 + 1);
    push_done(4'b0010, 4'd3, t0 + 6);
    for (int c = 1; c <= 7; c++) begin
      tick();
      check("single_clr", int'(cnt_clr), int'(c == 1));
      check("single_en", int'(cnt_en), int'(c >= 2 && c <= 4));
      check("single_busy", int'(busy), int'(c <= 6));
      if (c == 1) check("single_gnt_c1", int'(gnt), 2);
      if (c == 7) check("single_gnt_c7", int'(gnt), 0);
      if (c == 6) req = '0;
    end

    // Zero length
    len[3:0] = 4'd0;
    req = 4'b0001;
    t0  = cyc;
    push_gnt(4'b0001, t0 + 1);
    push_done(4'b0001, 4'd0, t0 + 3);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("zero_en", int'(cnt_en), 0);
      check("zero_busy", int'(busy), int'(c <= 3));
      if (c == 3) req = '0;
    end

    // Max count, no wrap
    len[11:8] = 4'd15;
    req = 4'b0100;
    t0  = cyc;
    push_gnt(4'b0100, t0 + 1);
    push_done(4'b0100, 4'd15, t0 + 18);
    for (int c = 1; c <= 19; c++) begin
      tick();
      check("max_en", int'(cnt_en), int'(c >= 2 && c <= 16));
      if (c >= 17) check("max_nowrap", int'(cnt_q), 15);
      if (c == 18) req = '0;
    end

    // Abort at cnt_q=2 of target 9
    len[15:12] = 4'd9;
    req = 4'b1000;
    t0  = cyc;
    push_gnt(4'b1000, t0 + 1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 4) begin
        check("abort_q2", int'(cnt_q), 2);
        req = '0;
      end
      if (c >= 5) begin
        check("abort_busy", int'(busy), 0);
        check("abort_gnt", int'(gnt), 0);
        check("abort_en", int'(cnt_en), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 15);
      end
    end

    // Reset mid-RUN at cnt_q=5
    len[7:4] = 4'd9;
    req = 4'b0010;
    t0  = cyc;
    push_gnt(4'b0010, t0 + 1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 7) check("midrst_q5", int'(cnt_q), 5);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_en", int'(cnt_en), 0);
    check("midrst_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    len = 16'h1111;
    req = 4'b1111;
    t0  = cyc;
    push_gnt(4'b0001, t0 + 1);
    push_done(4'b0001, 4'd1, t0 + 4);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) req = '0;
      if (c == 5) check("post_rst_idle", int'(busy), 0);
    end

    repeat (3) tick();
    check("gnt_queue_drained", q_gnt.size(), 0);
    check("done_queue_drained", q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_sched.md
Name: count_sched

Overview:
Round-robin scheduler that shares one W-bit up-counter among NREQ requesters.
- A granted requester supplies a target count. The scheduler clears the counter, enables it until it reaches the target, then reports completion and the final value.
- Sits between requester logic and the shared counter. It drives the counter's clear and enable and observes the counter's q.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, counter and target width in bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  request per requester; level, held until done or abandoned
len  input  NREQ*W  target count per requester; slice i = len[i*W +: W]
gnt  output  NREQ  one-hot grant, registered
done  output  NREQ  one-cycle completion pulse to the granted requester, registered
result  output  W  counter value captured at completion, registered
busy  output  1  high whenever state != IDLE
cnt_clr  output  1  synchronous clear to the shared counter
cnt_en  output  1  count enable to the shared counter
cnt_q  input  W  shared counter value

Behaviour:
- Interface: single clock, clk. Reset is asynchronous and active-low on rst_n.
- Counter contract: on each clk edge, cnt_clr gives q<=0, which takes priority over cnt_en; cnt_en gives q<=q+1; otherwise q holds.
- Reset values: state=IDLE, gnt=0, done=0, result=0, ptr=NREQ-1, target=0. cnt_clr=0, cnt_en=0, busy=0.
- ptr is the index of the last granted requester. Arbitration scans from ptr+1 upward, wrapping mod NREQ. The first asserted req wins, so out of reset req[0] has top priority.
- IDLE: if any req is set, register gnt one-hot, latch target=len slice of the winner, set ptr=winner, go to CLEAR. Otherwise stay in IDLE.
- CLEAR: cnt_clr=1 for exactly one cycle, cnt_en=0. Next state RUN.
- RUN:
  - cnt_en = (cnt_q != target), combinational; cnt_clr=0.
  - If req[winner]=0 (abort): go to IDLE and clear gnt. No done pulse; result unchanged.
  - Else if cnt_q == target: go to DONE.
- DONE:
  - done[winner]=1 and result=cnt_q, both registered so they are visible during the DONE cycle.
  - gnt cleared on exit. Next state IDLE.
  - A requester still holding req after done is re-arbitrated normally.
- Latency: req sampled in IDLE at cycle 0 gives:
  - gnt visible at cycle 1 (CLEAR)
  - RUN from cycle 2
  - cnt_q = target at cycle 2+target
  - done high at cycle 3+target
  - earliest next gnt at cycle 5+target
- target=0: no special case. RUN sees cnt_q=0=target, cnt_en never asserts, done at cycle 3, result=0.
- target=2^W-1: the counter never wraps because cnt_en drops at equality.
- len changes after grant are ignored, since target is latched. A req rising on a non-granted requester during a transaction waits; no preemption.
- gnt and done are always zero or one-hot, and done implies the matching gnt bit is set in the same cycle.
- Reset asserted mid-transaction: all outputs return to reset values immediately. The in-flight request is lost, and ptr returns to NREQ-1.

Test Plan:
- Single request: req[1]=1, len[1]=3 → gnt=0010 at cycle 1; cnt_clr high at cycle 1; cnt_en high cycles 2-4; done=0010 at cycle 6; result=3.
- Zero length: req[0]=1, len[0]=0 → cnt_en never high; done[0] at cycle 3; result=0.
- Contention: req=1111 held, all len=1 → grant order 0,1,2,3,0. Each transaction lasts 4 busy cycles plus 1 IDLE cycle. gnt is never multi-hot.
- Max count: len[2]=15 → cnt_q reaches 15 and stops with no wrap to 0; done[2] at cycle 18; result=15.
- Abort: req[3] dropped while cnt_q=2 of target 9 → IDLE next cycle; done stays 0; result holds its previous value; cnt_en=0.
- Reset mid-RUN: rst_n low while cnt_q=5 → gnt, done and busy go to 0 asynchronously. After release, req=1111 grants req[0] first.
